uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit path (the uart block's wr_uart/w_data/tx_full interface) between NREQ independent requesters, such as the CPU console, debug monitor and status reporter.
- Arbitrates round-robin at packet granularity. Once granted, a requester keeps the UART until its byte marked last is accepted, so packets never interleave on the serial line.
- Sits between the requesters and the uart block's TX FIFO write port.

---
 rtl/uart_tx_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter in front of the uart TX FIFO write port
//
// Purpose:
//   Shares one uart transmit path between NREQ requesters. A requester that wins
//   arbitration keeps the uart until its byte marked last is accepted, so packets
//   never interleave on the serial line. Arbitration is round-robin, starting the
//   search at the requester after the one most recently served.
//
// Optional feature (macro UART_ARB_ID_PREFIX_EN):
//   When defined, every packet is preceded by one ID byte {4'hF, g[3:0]}, where g
//   is the granted requester index. Requires DBIT == 8.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   [NREQ]       requester i presents a byte
//   req_last   in   [NREQ]       presented byte ends the packet
//   req_data   in   [NREQ*DBIT]  requester i byte at [i*DBIT +: DBIT]
//   req_ready  out  [NREQ]       requester i byte accepted this cycle
//   grant      out  [NREQ]       registered one-hot grant, zero when idle
//   busy       out  not in IDLE
//   tx_full    in   uart TX FIFO full
//   wr_uart    out  uart FIFO write strobe
//   w_data     out  [DBIT]       byte written to the uart FIFO
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  input  logic [NREQ*DBIT-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 busy,
  input  logic                 tx_full,
  output logic                 wr_uart,
  output logic [DBIT-1:0]      w_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = IW + 1;

  if (NREQ < 2 || NREQ > 16) begin : g_nreq_check
    $error("uart_tx_arbiter: NREQ must be in 2..16");
  end

`ifdef UART_ARB_ID_PREFIX_EN
  if (DBIT != 8) begin : g_dbit_check
    $error("uart_tx_arbiter: ID prefix requires DBIT == 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_PREFIX = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            busy_q, busy_d;

  logic            found;
  logic [IW-1:0]   sel_idx;
  logic [CW-1:0]   cand;
  logic            cur_valid;
  logic            cur_last;
  logic [DBIT-1:0] cur_data;
  logic [IW-1:0]   rr_next;
`ifdef UART_ARB_ID_PREFIX_EN
  logic [3:0]      gid4;
`endif

  assign cur_valid = req_valid[gidx_q];
  assign cur_last  = req_last[gidx_q];
  assign cur_data  = req_data[int'(gidx_q) * DBIT +: DBIT];

  // Explicit compare so non-power-of-two NREQ wraps correctly.
  assign rr_next = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;

`ifdef UART_ARB_ID_PREFIX_EN
  assign gid4 = 4'(gidx_q);
`endif

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + CW'(k);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!found && req_valid[cand[IW-1:0]]) begin
        found   = 1'b1;
        sel_idx = cand[IW-1:0];
      end
    end
  end

  // Datapath outputs are combinational from registered state so a byte can be
  // accepted in the same cycle the requester presents it.
  always_comb begin
    wr_uart   = 1'b0;
    w_data    = '0;
    req_ready = '0;
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          gidx_d           = sel_idx;
`ifdef UART_ARB_ID_PREFIX_EN
          state_d          = ST_PREFIX;
`else
          state_d          = ST_SEND;
`endif
        end
      end

`ifdef UART_ARB_ID_PREFIX_EN
      ST_PREFIX: begin
        wr_uart = ~tx_full;
        w_data  = DBIT'({4'hF, gid4});
        if (!tx_full) begin
          state_d = ST_SEND;
        end
      end
`endif

      ST_SEND: begin
        w_data = cur_data;
        if (cur_valid && !tx_full) begin
          wr_uart           = 1'b1;
          req_ready[gidx_q] = 1'b1;
          // Last byte ends the packet; the IDLE bubble that follows gives the
          // next requester in rotation a fair chance.
          if (cur_last) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = rr_next;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;

  logic                 clk;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic                 busy;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;

  int tests_run;
  int tests_failed;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant     (grant),
    .busy      (busy),
    .tx_full   (tx_full),
    .wr_uart   (wr_uart),
    .w_data    (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: captures bytes just before the rising edge that writes them.
  always @(negedge clk) begin
    #4;
    if (reset && wr_uart) fifo_q.push_back(w_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    check({tag, "_cnt"}, 32'(fifo_q.size()), 32'(exp_q.size()));
    if (fifo_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        check($sformatf("%s_b%0d", tag, i), 32'(fifo_q[i]), 32'(exp_q[i]));
      end
    end
    fifo_q.delete();
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
    req_valid[i]          = v;
    req_last[i]           = l;
    req_data[i*DBIT +: 8] = d;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_full   = 1'b0;

    next_cyc(); next_cyc();
    #1;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr", 32'(wr_uart), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wdata", 32'(w_data), 0);
    next_cyc();
    reset = 1'b1;

`ifdef UART_ARB_ID_PREFIX_EN
    next_cyc();
    set_req(2, 1'b1, 1'b1, 8'h55);
    #1;
    check("px_idle_wr", 32'(wr_uart), 0);
    next_cyc(); #1;
    check("px_grant", 32'(grant), 'h4);
    check("px_wr", 32'(wr_uart), 1);
    check("px_id", 32'(w_data), 'hF2);
    check("px_ready0", 32'(req_ready), 0);
    next_cyc(); #1;
    check("px_wr2", 32'(wr_uart), 1);
    check("px_data", 32'(w_data), 'h55);
    check("px_ready", 32'(req_ready), 'h4);
    next_cyc();
    set_req(2, 1'b0, 1'b0, 8'h00);
    #1;
    check("px_end_busy", 32'(busy), 0);
    exp_q = '{8'hF2, 8'h55};
    check_fifo("px_fifo");
`else
    // Single packet from requester 0.
    next_cyc();
    set_req(0, 1'b1, 1'b0, 8'hA1);
    #1;
    check("t1_pre_grant", 32'(grant), 0);
    check("t1_pre_wr", 32'(wr_uart), 0);
    next_cyc(); #1;
    check("t1_grant", 32'(grant), 'h1);
    check("t1_busy", 32'(busy), 1);
    check("t1_wr_a1", 32'(wr_uart), 1);
    check("t1_d_a1", 32'(w_data), 'hA1);
    check("t1_rdy_a1", 32'(req_ready), 'h1);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 8'hA2);
    #1;
    check("t1_wr_a2", 32'(wr_uart), 1);
    check("t1_d_a2", 32'(w_data), 'hA2);
    next_cyc();
    set_req(0, 1'b1, 1'b1, 8'hA3);
    #1;
    check("t1_wr_a3", 32'(wr_uart), 1);
    check("t1_d_a3", 32'(w_data), 'hA3);
    check("t1_rdy_a3", 32'(req_ready), 'h1);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 8'h00);
    #1;
    check("t1_end_grant", 32'(grant), 0);
    check("t1_end_busy", 32'(busy), 0);
    exp_q = '{8'hA1, 8'hA2, 8'hA3};
    check_fifo("t1_fifo");

    // Contention after a fresh reset (rr_ptr back to 0).
    reset = 1'b0;
    next_cyc();
    reset = 1'b1;
    set_req(0, 1'b1, 1'b1, 8'h30);
    set_req(2, 1'b1, 1'b1, 8'h32);
    next_cyc(); #1;
    check("t2_g0", 32'(grant), 'h1);
    check("t2_d0", 32'(w_data), 'h30);
    check("t2_rdy0", 32'(req_ready), 'h1);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 8'h00);
    #1;
    check("t2_bubble_grant", 32'(grant), 0);
    check("t2_bubble_rdy", 32'(req_ready), 0);
    next_cyc(); #1;
    check("t2_g2", 32'(grant), 'h4);
    check("t2_d2", 32'(w_data), 'h32);
    check("t2_rdy2", 32'(req_ready), 'h4);
    next_cyc();
    set_req(2, 1'b0, 1'b0, 8'h00);
    set_req(0, 1'b1, 1'b1, 8'h40);
    set_req(1, 1'b1, 1'b1, 8'h41);
    next_cyc(); #1;
    check("t2_wrap_g0", 32'(grant), 'h1);
    check("t2_wrap_d0", 32'(w_data), 'h40);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 8'h00);
    next_cyc(); #1;
    check("t2_g1", 32'(grant), 'h2);
    check("t2_d1", 32'(w_data), 'h41);
    next_cyc();
    set_req(1, 1'b0, 1'b0, 8'h00);
    exp_q = '{8'h30, 8'h32, 8'h40, 8'h41};
    check_fifo("t2_fifo");

    // Backpressure on the second byte of a 4-byte packet (rr_ptr = 2).
    set_req(0, 1'b1, 1'b0, 8'h10);
    next_cyc(); #1;
    check("t3_g0", 32'(grant), 'h1);
    check("t3_d10", 32'(w_data), 'h10);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 8'h11);
    tx_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t3_stall_wr%0d", i), 32'(wr_uart), 0);
      check($sformatf("t3_stall_rdy%0d", i), 32'(req_ready), 0);
      check($sformatf("t3_stall_g%0d", i), 32'(grant), 'h1);
      next_cyc();
    end
    tx_full = 1'b0;
    #1;
    check("t3_wr11", 32'(wr_uart), 1);
    check("t3_d11", 32'(w_data), 'h11);
    next_cyc();
    set_req(0, 1'b1, 1'b0, 8'h12);
    next_cyc();
    set_req(0, 1'b1, 1'b1, 8'h13);
    next_cyc();
    set_req(0, 1'b0, 1'b0, 8'h00);
    #1;
    check("t3_end_busy", 32'(busy), 0);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    check_fifo("t3_fifo");

    // Mid-packet gap from requester 1 while requester 3 waits (rr_ptr = 1).
    set_req(1, 1'b1, 1'b0, 8'h21);
    set_req(3, 1'b1, 1'b1, 8'h3F);
    next_cyc(); #1;
    check("t4_g1", 32'(grant), 'h2);
    check("t4_d21", 32'(w_data), 'h21);
    next_cyc();
    set_req(1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("t4_gap_g%0d", i), 32'(grant), 'h2);
      check($sformatf("t4_gap_rdy%0d", i), 32'(req_ready), 0);
      check($sformatf("t4_gap_wr%0d", i), 32'(wr_uart), 0);
      next_cyc();
    end
    set_req(1, 1'b1, 1'b0, 8'h22);
    #1;
    check("t4_d22", 32'(w_data), 'h22);
    next_cyc();
    set_req(1, 1'b1, 1'b1, 8'h23);
    next_cyc();
    set_req(1, 1'b0, 1'b0, 8'h00);
    #1;
    check("t4_bubble_g", 32'(grant), 0);
    check("t4_bubble_rdy", 32'(req_ready), 0);
    next_cyc(); #1;
    check("t4_g3", 32'(grant), 'h8);
    check("t4_d3f", 32'(w_data), 'h3F);
    check("t4_rdy3", 32'(req_ready), 'h8);
    next_cyc();
    set_req(3, 1'b0, 1'b0, 8'h00);
    exp_q = '{8'h21, 8'h22, 8'h23, 8'h3F};
    check_fifo("t4_fifo");

    // Reset mid-packet; first move rr_ptr away from 0.
    set_req(1, 1'b1, 1'b1, 8'h50);
    next_cyc(); #1;
    check("t5_g1a", 32'(grant), 'h2);
    next_cyc();
    set_req(1, 1'b0, 1'b0, 8'h00);
    next_cyc();
    set_req(1, 1'b1, 1'b0, 8'h51);
    next_cyc(); #1;
    check("t5_d51", 32'(w_data), 'h51);
    next_cyc();
    set_req(1, 1'b1, 1'b0, 8'h52);
    #1;
    check("t5_pre_wr", 32'(wr_uart), 1);
    #1;
    reset = 1'b0;
    #1;
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_wr", 32'(wr_uart), 0);
    check("t5_rst_rdy", 32'(req_ready), 0);
    check("t5_rst_busy", 32'(busy), 0);
    next_cyc();
    reset = 1'b1;
    set_req(1, 1'b1, 1'b1, 8'h61);
    set_req(3, 1'b1, 1'b1, 8'h63);
    next_cyc(); #1;
    check("t5_after_g1", 32'(grant), 'h2);
    check("t5_after_d", 32'(w_data), 'h61);
    next_cyc();
    set_req(1, 1'b0, 1'b0, 8'h00);
    next_cyc(); #1;
    check("t5_after_g3", 32'(grant), 'h8);
    next_cyc();
    set_req(3, 1'b0, 1'b0, 8'h00);
    #1;
    check("t5_end_busy", 32'(busy), 0);
    exp_q = '{8'h50, 8'h51, 8'h61, 8'h63};
    check_fifo("t5_fifo");
`endif

    next_cyc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
